// File: rtl/dice_roll_ctrl_if.sv
// dice_roll_ctrl_if
//   Groups the control strobes and the display/result outputs of the
//   two-die sequencer.
//   tick, start, stop : update strobe and roll control pulses (to the sequencer)
//   dice1, dice2      : die values for the dot-matrix scanner, 0 = blank
//   rolling, done     : rolling is high in ROLL/SLOW, done is high in RESULT
//   winner            : 00 none, 01 dice1 higher, 10 dice2 higher, 11 tie
//   master modport drives the strobes; slave modport is the sequencer side.
interface dice_roll_ctrl_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic [3:0] dice1;
  logic [3:0] dice2;
  logic       rolling;
  logic       done;
  logic [1:0] winner;

  modport master (
    output tick, start, stop,
    input  dice1, dice2, rolling, done, winner
  );

  modport slave (
    input  tick, start, stop,
    output dice1, dice2, rolling, done, winner
  );
endinterface

// File: rtl/dice_roll_ctrl.sv
// dice_roll_ctrl
//   Sequencer for the two-die dot-matrix display. Both dice spin while
//   rolling, decelerate for SLOW_STEPS updates after stop, then settle and
//   the winner is registered until the next roll.
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : dice_roll_ctrl_if.slave (tick/start/stop in; dice/status out)
module dice_roll_ctrl #(
  parameter int          MAX_FACE   = 6,
  parameter int          ROLL_DIV   = 4,
  parameter int          SLOW_STEPS = 5,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  dice_roll_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ROLL, SLOW, RESULT} state_t;

  localparam logic [4:0] MAX_F     = 5'(MAX_FACE);
  localparam logic [7:0] ROLL_DIV8 = 8'(ROLL_DIV);
  localparam logic [3:0] LAST_STEP = 4'(SLOW_STEPS - 1);

  state_t      state_q, state_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [3:0]  dice1_q, dice1_d;
  logic [3:0]  dice2_q, dice2_d;
  logic [1:0]  winner_q, winner_d;

  logic [3:0]  face1_nxt, face2_nxt;
  logic [7:0]  tick_inc;
  logic [7:0]  slow_tgt;

  // Advance a die by 1..4 pips with wrap; one subtraction is enough since
  // the step never exceeds MAX_FACE.
  function automatic logic [3:0] next_face(input logic [3:0] die,
                                           input logic [1:0] rnd);
    logic [4:0] n;
    n = {1'b0, die} + {3'b000, rnd} + 5'd1;
    if (n > MAX_F) n = n - MAX_F;
    return n[3:0];
  endfunction

  function automatic logic [1:0] judge(input logic [3:0] d1,
                                       input logic [3:0] d2);
    if (d1 > d2)      return 2'b01;
    else if (d2 > d1) return 2'b10;
    else              return 2'b11;
  endfunction

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_d    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign face1_nxt = next_face(dice1_q, lfsr_q[1:0]);
  assign face2_nxt = next_face(dice2_q, lfsr_q[9:8]);
  assign tick_inc  = tick_cnt_q + 8'd1;
  // Deceleration: update k waits ROLL_DIV*(k+2) ticks (max 240, fits 8 bits).
  assign slow_tgt  = 8'(ROLL_DIV * (int'(step_q) + 2));

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    step_d     = step_q;
    dice1_d    = dice1_q;
    dice2_d    = dice2_q;
    winner_d   = winner_q;
    unique case (state_q)
      IDLE, RESULT: begin
        if (bus.start) begin
          state_d    = ROLL;
          dice1_d    = 4'd1;
          dice2_d    = 4'd1;
          tick_cnt_d = 8'd0;
          step_d     = 4'd0;
          winner_d   = 2'b00;
        end
      end
      ROLL: begin
        // stop has priority over a coinciding tick and over start
        if (bus.stop) begin
          state_d    = SLOW;
          tick_cnt_d = 8'd0;
          step_d     = 4'd0;
        end else if (bus.tick) begin
          if (tick_inc == ROLL_DIV8) begin
            dice1_d    = face1_nxt;
            dice2_d    = face2_nxt;
            tick_cnt_d = 8'd0;
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      SLOW: begin
        if (bus.tick) begin
          if (tick_inc == slow_tgt) begin
            dice1_d    = face1_nxt;
            dice2_d    = face2_nxt;
            tick_cnt_d = 8'd0;
            step_d     = step_q + 4'd1;
            if (step_q == LAST_STEP) begin
              state_d  = RESULT;
              step_d   = 4'd0;
              winner_d = judge(face1_nxt, face2_nxt);
            end
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= 8'd0;
      step_q     <= 4'd0;
      lfsr_q     <= LFSR_SEED;
      dice1_q    <= 4'd0;
      dice2_q    <= 4'd0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      step_q     <= step_d;
      lfsr_q     <= lfsr_d;
      dice1_q    <= dice1_d;
      dice2_q    <= dice2_d;
      winner_q   <= winner_d;
    end
  end

  assign bus.dice1   = dice1_q;
  assign bus.dice2   = dice2_q;
  assign bus.rolling = (state_q == ROLL) || (state_q == SLOW);
  assign bus.done    = (state_q == RESULT);
  assign bus.winner  = winner_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
module tb_dice_roll_ctrl;
  localparam int ROLL_DIV   = 4;
  localparam int SLOW_STEPS = 5;
  localparam int MAXF       = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0;

  always #5 clk = ~clk;

  dice_roll_ctrl_if bus6 ();
  dice_roll_ctrl_if bus9 ();

  assign bus6.tick  = tick;
  assign bus6.start = start;
  assign bus6.stop  = stop;
  assign bus9.tick  = tick;
  assign bus9.start = start;
  assign bus9.stop  = stop;

  dice_roll_ctrl #(.MAX_FACE(6), .ROLL_DIV(ROLL_DIV), .SLOW_STEPS(SLOW_STEPS),
                   .LFSR_SEED(16'hACE1))
    dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

  dice_roll_ctrl #(.MAX_FACE(9), .ROLL_DIV(ROLL_DIV), .SLOW_STEPS(SLOW_STEPS),
                   .LFSR_SEED(16'hACE1))
    dut9 (.clk(clk), .rst(rst), .bus(bus9.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard queue ----------------
  typedef struct packed {
    int         cyc;
    logic [3:0] d1;
    logic [3:0] d2;
    logic       rol;
    logic       dn;
    logic [1:0] win;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  int          m_st = 0, m_cnt = 0, m_k = 0;
  int          m_d1 = 0, m_d2 = 0, m_win = 0;

  function automatic int ref_face(input int die, input int stp);
    int n;
    n = die + stp;
    return (n > MAXF) ? n - MAXF : n;
  endfunction

  function automatic logic [15:0] ref_lfsr(input logic [15:0] l);
    logic fb;
    fb = l[0];
    l  = l >> 1;
    if (fb) l = l ^ 16'hB400;
    return l;
  endfunction

  initial begin
    exp_t last, now;
    int   s1, s2;
    last = '{cyc: 0, d1: 4'd0, d2: 4'd0, rol: 1'b0, dn: 1'b0, win: 2'b00};
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_st = 0; m_cnt = 0; m_k = 0; m_d1 = 0; m_d2 = 0; m_win = 0;
        m_lfsr = 16'hACE1;
        now.cyc = -1;
      end else begin
        cyc++;
        s1 = 1 + int'(m_lfsr[1:0]);
        s2 = 1 + int'(m_lfsr[9:8]);
        case (m_st)
          0, 3: if (start) begin
            m_st = 1; m_d1 = 1; m_d2 = 1; m_cnt = 0; m_k = 0; m_win = 0;
          end
          1: begin
            if (stop) begin
              m_st = 2; m_cnt = 0; m_k = 0;
            end else if (tick) begin
              m_cnt++;
              if (m_cnt == ROLL_DIV) begin
                m_d1 = ref_face(m_d1, s1); m_d2 = ref_face(m_d2, s2); m_cnt = 0;
              end
            end
          end
          default: begin
            if (tick) begin
              m_cnt++;
              if (m_cnt == ROLL_DIV * (m_k + 2)) begin
                m_d1 = ref_face(m_d1, s1); m_d2 = ref_face(m_d2, s2); m_cnt = 0;
                m_k++;
                if (m_k == SLOW_STEPS) begin
                  m_st  = 3; m_k = 0;
                  m_win = (m_d1 > m_d2) ? 1 : (m_d2 > m_d1) ? 2 : 3;
                end
              end
            end
          end
        endcase
        m_lfsr  = ref_lfsr(m_lfsr);
        now.cyc = cyc;
      end
      now.d1  = 4'(m_d1);
      now.d2  = 4'(m_d2);
      now.rol = (m_st == 1) || (m_st == 2);
      now.dn  = (m_st == 3);
      now.win = 2'(m_win);
      if ({now.d1, now.d2, now.rol, now.dn, now.win} !==
          {last.d1, last.d2, last.rol, last.dn, last.win}) begin
        sb_q.push_back(now);
        last = now;
      end
    end
  end

  // ---------------- monitor ----------------
  bit seen6a[10], seen6b[10], seen9a[10], seen9b[10];

  initial begin
    logic [11:0] prev6, cur6;
    logic [7:0]  prev9, cur9;
    exp_t        e;
    bit          first = 1'b1;
    forever begin
      @(negedge clk);
      cur6 = {bus6.dice1, bus6.dice2, bus6.rolling, bus6.done, bus6.winner};
      cur9 = {bus9.dice1, bus9.dice2};
      if (!first && cur6 !== prev6) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_change", 1, 0);
        end else begin
          e = sb_q.pop_front();
          if (e.cyc >= 0) chk("sb_cycle", cyc, e.cyc);
          chk("sb_dice1", bus6.dice1, e.d1);
          chk("sb_dice2", bus6.dice2, e.d2);
          chk("sb_rolling", bus6.rolling, e.rol);
          chk("sb_done", bus6.done, e.dn);
          chk("sb_winner", bus6.winner, e.win);
        end
        if (bus6.rolling && cur6[11:4] !== prev6[11:4]) begin
          chk("range6_d1", int'(bus6.dice1 >= 1 && bus6.dice1 <= 6), 1);
          chk("range6_d2", int'(bus6.dice2 >= 1 && bus6.dice2 <= 6), 1);
          seen6a[bus6.dice1] = 1'b1;
          seen6b[bus6.dice2] = 1'b1;
        end
      end
      if (!first && cur9 !== prev9 && bus9.rolling) begin
        chk("range9_d1", int'(bus9.dice1 >= 1 && bus9.dice1 <= 9), 1);
        chk("range9_d2", int'(bus9.dice2 >= 1 && bus9.dice2 <= 9), 1);
        seen9a[bus9.dice1] = 1'b1;
        seen9b[bus9.dice2] = 1'b1;
      end
      prev6 = cur6;
      prev9 = cur9;
      first = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic t, input logic s, input logic p);
    tick = t; start = s; stop = p;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  int exp_upd[5] = '{8, 20, 36, 56, 80};

  initial begin
    int n, nupd, chg, w;
    int upd_at[5];
    logic [3:0] pd1, pd2;
    logic [1:0] pw;

    // reset held with tick toggling
    repeat (4) step(1'b1, 1'b0, 1'b0);
    chk("rst_dice1", bus6.dice1, 0);
    chk("rst_dice2", bus6.dice2, 0);
    chk("rst_rolling", bus6.rolling, 0);
    chk("rst_done", bus6.done, 0);
    chk("rst_winner", bus6.winner, 0);
    chk("rst9_dice1", bus9.dice1, 0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b1);   // stop ignored in IDLE
    chk("idle_stop_rolling", bus6.rolling, 0);

    // start -> ROLL with 1/1
    step(1'b0, 1'b1, 1'b0);
    chk("start_dice1", bus6.dice1, 1);
    chk("start_dice2", bus6.dice2, 1);
    chk("start_rolling", bus6.rolling, 1);
    chk("start_done", bus6.done, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("roll_hold_t%0d", i), int'(bus6.dice1 == 1 && bus6.dice2 == 1), 1);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("roll_upd_t4_d1", int'(bus6.dice1 >= 2 && bus6.dice1 <= 5), 1);
    chk("roll_upd_t4_d2", int'(bus6.dice2 >= 2 && bus6.dice2 <= 5), 1);
    repeat (9) step(1'b1, 1'b0, 1'b0);

    // stop -> SLOW, count ticks to each update and to done
    pd1 = bus6.dice1; pd2 = bus6.dice2;
    step(1'b1, 1'b0, 1'b1);   // coinciding tick must not update
    chk("stop_no_update", int'(bus6.dice1 == pd1 && bus6.dice2 == pd2), 1);
    chk("slow_rolling", bus6.rolling, 1);
    n = 0; nupd = 0;
    for (int i = 0; i < 5; i++) upd_at[i] = 0;
    while (bus6.done !== 1'b1 && n < 200) begin
      pd1 = bus6.dice1; pd2 = bus6.dice2;
      step(1'b1, 1'b0, 1'b0);
      n++;
      if (bus6.dice1 !== pd1 || bus6.dice2 !== pd2) begin
        if (nupd < 5) upd_at[nupd] = n;
        nupd++;
      end
    end
    chk("slow_update_count", nupd, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("slow_upd%0d_tick", i), upd_at[i], exp_upd[i]);
    chk("ticks_to_done", n, 80);
    chk("result_rolling", bus6.rolling, 0);
    w = (bus6.dice1 > bus6.dice2) ? 1 : (bus6.dice2 > bus6.dice1) ? 2 : 3;
    chk("winner6", bus6.winner, w);
    w = (bus9.dice1 > bus9.dice2) ? 1 : (bus9.dice2 > bus9.dice1) ? 2 : 3;
    chk("winner9", bus9.winner, w);

    // RESULT: stop and ticks ignored
    pd1 = bus6.dice1; pd2 = bus6.dice2; pw = bus6.winner;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("result_hold", int'(bus6.dice1 == pd1 && bus6.dice2 == pd2 &&
                            bus6.winner == pw && bus6.done == 1'b1), 1);

    // start+stop in RESULT: start wins
    step(1'b0, 1'b1, 1'b1);
    chk("restart_winner", bus6.winner, 0);
    chk("restart_done", bus6.done, 0);
    chk("restart_dice", int'(bus6.dice1 == 1 && bus6.dice2 == 1), 1);
    chk("restart_rolling", bus6.rolling, 1);

    // start+stop in ROLL: stop wins, first SLOW update on tick 8
    step(1'b0, 1'b1, 1'b1);
    chk("ss_roll_dice", int'(bus6.dice1 == 1 && bus6.dice2 == 1), 1);
    chg = 0;
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus6.dice1 != 1 || bus6.dice2 != 1) chg = 1;
    end
    chk("ss_slow_hold", chg, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("ss_slow_first_upd", int'(bus6.dice1 != 1 && bus6.dice2 != 1), 1);

    // reach k=2, then reset mid-interval
    repeat (12) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_dice1", bus6.dice1, 0);
    chk("midrst_dice2", bus6.dice2, 0);
    chk("midrst_rolling", bus6.rolling, 0);
    chk("midrst_done", bus6.done, 0);
    chk("midrst_winner", bus6.winner, 0);
    chk("midrst9_dice", int'(bus9.dice1 == 0 && bus9.dice2 == 0), 1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    chk("fresh_dice", int'(bus6.dice1 == 1 && bus6.dice2 == 1), 1);
    chg = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus6.dice1 != 1 || bus6.dice2 != 1) chg = 1;
    end
    chk("fresh_hold", chg, 0);
    step(1'b1, 1'b0, 1'b0);
    chk("fresh_upd_t4", int'(bus6.dice1 != 1 && bus6.dice2 != 1), 1);

    // long ROLL run (about 2000 updates) on both instances
    repeat (8000) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    n = 0;
    while (bus6.done !== 1'b1 && n < 200) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    chk("long_ticks_to_done", n, 80);
    step(1'b0, 1'b0, 1'b0);

    for (int f = 1; f <= 6; f++) begin
      chk($sformatf("cover6_d1_face%0d", f), int'(seen6a[f]), 1);
      chk($sformatf("cover6_d2_face%0d", f), int'(seen6b[f]), 1);
    end
    for (int f = 1; f <= 9; f++) begin
      chk($sformatf("cover9_d1_face%0d", f), int'(seen9a[f]), 1);
      chk($sformatf("cover9_d2_face%0d", f), int'(seen9b[f]), 1);
    end
    chk("sb_queue_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
- Sequencer for the two-die dot-matrix display path. Generates the values for both dice: they spin while rolling, slow down after stop, then settle on a result.
- Declares the winner and holds the result until the next roll.
- Outputs dice1/dice2 feed the dot-matrix scanner directly: 0 = blank, 1..MAX_FACE = pips.
- Control inputs start/stop are debounced, single-cycle pulses in the clk domain.

Parameters:
- MAX_FACE, 6, highest die face; legal range 4..9.
- ROLL_DIV, 4, tick pulses between die updates in ROLL; legal range 1..15.
- SLOW_STEPS, 5, number of decelerating updates after stop; legal range 1..15.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle update strobe from the prescaler (e.g. 100 Hz).
- start  input  1  one-cycle pulse, begin roll.
- stop  input  1  one-cycle pulse, stop roll.
- dice1  output  4  red die value; 0 = blank.
- dice2  output  4  green die value; 0 = blank.
- rolling  output  1  high in ROLL and SLOW.
- done  output  1  high in RESULT.
- winner  output  2  00 no result, 01 dice1 higher, 10 dice2 higher, 11 tie.

Behaviour:
- Reset (rst=0, async): state=IDLE, dice1=dice2=0, rolling=0, done=0, winner=00, tick counter=0, step counter=0, lfsr=LFSR_SEED.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every clk cycle in every state while rst=1. It never reaches 0.
- Die update rule, applied to both dice in the same cycle:
  - dice1 step s1 = 1 + lfsr[1:0]; dice2 step s2 = 1 + lfsr[9:8]; each step is 1..4.
  - n = die + s (5-bit). If n > MAX_FACE, the new value is n - MAX_FACE, else n.
  - A single subtraction suffices because s ≤ 4 ≤ MAX_FACE. The result is always 1..MAX_FACE.
- Outputs are registered: an update decided at clock edge k is visible after edge k.
- State machine:
  - IDLE: dice blank.
    - start → ROLL. On the entry edge: dice1=dice2=1, tick counter=0.
    - stop ignored.
  - ROLL: rolling=1.
    - On each tick, tick counter increments. When the counter would reach ROLL_DIV: update both dice, counter=0. The first update is therefore on the ROLL_DIV-th tick after entry.
    - stop → SLOW on the next edge, with tick counter=0 and step counter k=0. Dice are not updated on that edge, even if a tick coincides.
    - start ignored.
  - SLOW: rolling=1.
    - Update k (k = 0..SLOW_STEPS-1) occurs on the ROLL_DIV*(k+2)-th tick counted since the previous update, or since SLOW entry for k=0. After each update: counter=0, k=k+1.
    - When update SLOW_STEPS-1 is applied, the same edge moves to RESULT.
    - start and stop ignored.
  - RESULT: rolling=0, done=1, dice held.
    - winner is registered on the entry edge from the final dice values: 01 if dice1>dice2, 10 if dice2>dice1, 11 if equal.
    - start → ROLL: winner=00, done=0, dice reloaded to 1/1, counter=0.
    - stop ignored.
- Simultaneous events:
  - start & stop in the same cycle in IDLE or RESULT: start wins.
  - start & stop in the same cycle in ROLL: stop wins.
- Tick counter width is 8 bits. The maximum interval needed is ROLL_DIV*(SLOW_STEPS+1) = 240.
- Ticks while in IDLE or RESULT are ignored and the counter holds at 0.
- Reset asserted mid-roll or mid-result: immediate return to the reset values. No partial result is retained.
- Total ticks from stop to done = ROLL_DIV * sum over k=0..SLOW_STEPS-1 of (k+2). With the default parameters this is 80.

Test Plan:
- Reset with tick toggling → dice1=dice2=0, winner=00, rolling=done=0. After start: dice=1/1, rolling=1 on the next cycle.
- Default parameters, start then 4 tick pulses → dice change only on the edge after the 4th tick. They are unchanged after ticks 1–3.
- 2000 ROLL updates with MAX_FACE=6, and separately with MAX_FACE=9 → every sampled value is within 1..MAX_FACE, never 0, and every face appears at least once.
- stop during ROLL, defaults → SLOW updates after 8, 12, 16, 20, 24 ticks. done=1 after exactly 80 ticks, and winner matches the held dice1/dice2 comparison (01/10/11).
- In RESULT: stop → no change. start → winner=00, done=0, dice=1/1, rolling=1. start+stop together in ROLL → enters SLOW, start ignored.
- Assert rst during SLOW (k=2) → all outputs return to reset values immediately. A subsequent start begins a fresh ROLL with counter=0.
